// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared defaults and named source indices for the bus arbiter/mux
package bus_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int BUS_NSRC  = 26;

    // Named source slots on the shared bus
    localparam int R0   = 0;
    localparam int R1   = 1;
    localparam int R2   = 2;
    localparam int R3   = 3;
    localparam int R4   = 4;
    localparam int R5   = 5;
    localparam int R6   = 6;
    localparam int R7   = 7;
    localparam int R8   = 8;
    localparam int R9   = 9;
    localparam int R10  = 10;
    localparam int R11  = 11;
    localparam int R12  = 12;
    localparam int R13  = 13;
    localparam int R14  = 14;
    localparam int R15  = 15;
    localparam int HI   = 16;
    localparam int LO   = 17;
    localparam int ZHI  = 18;
    localparam int ZLO  = 19;
    localparam int PC   = 20;
    localparam int MDR  = 21;
    localparam int PORT = 22;
    localparam int IR   = 23;
    localparam int RA   = 24;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - fixed-priority or pointer-rotated priority search over a request vector
module rr_picker
    import bus_pkg::*;
#(
    parameter int N  = BUS_NSRC,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          rr_mode,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] index,
    output logic          any,
    output logic          multi
);

    int j;

    // Pick the winner index; later assignments override earlier ones, so the
    // loop order encodes the priority (highest index in fixed mode, closest
    // at-or-above ptr in round-robin mode).
    always_comb begin
        index = '0;
        j     = 0;
        if (!rr_mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) index = PW'(i);
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
                if (req[j]) index = PW'(j);
            end
        end
    end

    // Summary flags and one-hot form of the chosen index
    always_comb begin
        any    = |req;
        multi  = |(req & (req - 1'b1));
        winner = any ? ({{(N-1){1'b0}}, 1'b1} << index) : '0;
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// rtl/bus_arbiter_mux.sv - registered shared-bus mux with fixed/round-robin arbitration and conflict status
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = BUS_NSRC,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_out,
    input  logic                  rr_mode,
    input  logic                  conflict_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic [NSRC-1:0]       grant,
    output logic                  bus_valid,
    output logic                  conflict,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [WIDTH-1:0] bus_q, bus_d;
    logic [NSRC-1:0]  grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [NSRC-1:0]  win_oh;
    logic [PW-1:0]    win_idx;
    logic             win_any;
    logic             win_multi;

    rr_picker #(
        .N  (NSRC),
        .PW (PW)
    ) u_pick (
        .req     (src_out),
        .ptr     (ptr_q),
        .rr_mode (rr_mode),
        .winner  (win_oh),
        .index   (win_idx),
        .any     (win_any),
        .multi   (win_multi)
    );

    // Next bus value, grant and rotation pointer; bus holds when nobody drives
    always_comb begin
        bus_d   = bus_q;
        grant_d = '0;
        valid_d = 1'b0;
        ptr_d   = ptr_q;
        if (win_any) begin
            bus_d   = src_data[int'(win_idx)*WIDTH +: WIDTH];
            grant_d = win_oh;
            valid_d = 1'b1;
            if (rr_mode) begin
                ptr_d = (win_idx == PW'(NSRC - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // Sticky conflict flag and saturating counter; a same-cycle conflict wins over clear
    always_comb begin
        conflict_d = conflict_q;
        cnt_d      = cnt_q;
        if (conflict_clr) begin
            conflict_d = 1'b0;
            cnt_d      = '0;
        end
        if (win_multi) begin
            conflict_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_q      <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
            ptr_q      <= '0;
        end else begin
            bus_q      <= bus_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus_out      = bus_q;
    assign grant        = grant_q;
    assign bus_valid    = valid_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb/tb_bus_arbiter_mux.sv - self-checking bench for bus_arbiter_mux with a behavioural model
module tb_bus_arbiter_mux;

    localparam int W = 32;
    localparam int N = 26;

    logic            clk;
    logic            clr;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    src_out;
    logic            rr_mode;
    logic            conflict_clr;

    logic [W-1:0]    bus_out, bus_out2;
    logic [N-1:0]    grant, grant2;
    logic            bus_valid, bus_valid2;
    logic            conflict, conflict2;
    logic [7:0]      conflict_cnt;
    logic [1:0]      conflict_cnt2;

    bus_arbiter_mux dut (
        .clk          (clk),
        .clr          (clr),
        .src_data     (src_data),
        .src_out      (src_out),
        .rr_mode      (rr_mode),
        .conflict_clr (conflict_clr),
        .bus_out      (bus_out),
        .grant        (grant),
        .bus_valid    (bus_valid),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    bus_arbiter_mux #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .clr          (clr),
        .src_data     (src_data),
        .src_out      (src_out),
        .rr_mode      (rr_mode),
        .conflict_clr (conflict_clr),
        .bus_out      (bus_out2),
        .grant        (grant2),
        .bus_valid    (bus_valid2),
        .conflict     (conflict2),
        .conflict_cnt (conflict_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [W-1:0] m_bus;
    logic [N-1:0] m_grant;
    logic         m_valid;
    logic         m_conf;
    int           m_cnt;
    int           m_cnt2;
    int           m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bus = '0; m_grant = '0; m_valid = 1'b0; m_conf = 1'b0;
        m_cnt = 0; m_cnt2 = 0; m_ptr = 0;
    endtask

    // Apply the arbitration rules to the inputs present at the clock edge
    task automatic model_edge();
        int nreq;
        int w;
        nreq = $countones(src_out);
        w = -1;
        if (nreq == 0) begin
            m_grant = '0;
            m_valid = 1'b0;
        end else begin
            if (!rr_mode) begin
                for (int i = N - 1; i >= 0 && w < 0; i--) if (src_out[i]) w = i;
            end else begin
                for (int k = 0; k < N && w < 0; k++) if (src_out[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_ptr = (w + 1) % N;
            end
            m_bus   = src_data[w*W +: W];
            m_grant = '0;
            m_grant[w] = 1'b1;
            m_valid = 1'b1;
        end
        if (nreq >= 2) begin
            m_conf = 1'b1;
            m_cnt  = conflict_clr ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
            m_cnt2 = conflict_clr ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
        end else if (conflict_clr) begin
            m_conf = 1'b0;
            m_cnt  = 0;
            m_cnt2 = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".bus"},   64'(bus_out),       64'(m_bus));
        chk({tag, ".grant"}, 64'(grant),         64'(m_grant));
        chk({tag, ".valid"}, 64'(bus_valid),     64'(m_valid));
        chk({tag, ".conf"},  64'(conflict),      64'(m_conf));
        chk({tag, ".cnt"},   64'(conflict_cnt),  64'(m_cnt));
        chk({tag, ".bus2"},  64'(bus_out2),      64'(m_bus));
        chk({tag, ".grant2"},64'(grant2),        64'(m_grant));
        chk({tag, ".valid2"},64'(bus_valid2),    64'(m_valid));
        chk({tag, ".conf2"}, 64'(conflict2),     64'(m_conf));
        chk({tag, ".cnt2"},  64'(conflict_cnt2), 64'(m_cnt2));
    endtask

    // One clock: inputs already driven, advance model at the edge, sample 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) src_data[i*W +: W] = $urandom;
    endtask

    initial begin
        logic [N-1:0] req;
        logic [N-1:0] g;

        clr = 1'b1; src_out = '0; rr_mode = 1'b0; conflict_clr = 1'b0;
        rand_data();
        model_reset();
        #12;
        chk("reset.bus",   64'(bus_out),      64'd0);
        chk("reset.grant", 64'(grant),        64'd0);
        chk("reset.cnt",   64'(conflict_cnt), 64'd0);

        // Deassert away from the edge, then reset again mid-cycle with a pending request
        clr = 1'b0;
        src_out = '0;
        src_out[3] = 1'b1;
        step();
        check_model("run3");
        #2 clr = 1'b1;
        model_reset();
        #1;
        chk("midrst.bus",   64'(bus_out),   64'd0);
        chk("midrst.grant", 64'(grant),     64'd0);
        chk("midrst.valid", 64'(bus_valid), 64'd0);
        #2 clr = 1'b0;
        step();
        chk("rel.bus", 64'(bus_out), 64'(src_data[3*W +: W]));
        check_model("rel");

        // Single source then idle
        src_data[5*W +: W] = 32'hDEAD_BEEF;
        src_out = '0; src_out[5] = 1'b1;
        step();
        chk("single.bus",   64'(bus_out),   64'hDEAD_BEEF);
        g = '0; g[5] = 1'b1;
        chk("single.grant", 64'(grant),     64'(g));
        chk("single.valid", 64'(bus_valid), 64'd1);
        src_out = '0;
        step();
        chk("idle.bus",   64'(bus_out),   64'hDEAD_BEEF);
        chk("idle.valid", 64'(bus_valid), 64'd0);
        chk("idle.grant", 64'(grant),     64'd0);

        // Fixed-priority conflict: highest index wins
        src_out = '0; src_out[2] = 1'b1; src_out[20] = 1'b1;
        step();
        g = '0; g[20] = 1'b1;
        chk("fixed.grant", 64'(grant),        64'(g));
        chk("fixed.conf",  64'(conflict),     64'd1);
        chk("fixed.cnt",   64'(conflict_cnt), 64'd1);
        check_model("fixed");

        // Clear, then round-robin over {1,4,7} for four cycles
        src_out = '0; conflict_clr = 1'b1;
        step();
        conflict_clr = 1'b0;
        chk("clr.cnt", 64'(conflict_cnt), 64'd0);
        rr_mode = 1'b1;
        src_out = '0; src_out[1] = 1'b1; src_out[4] = 1'b1; src_out[7] = 1'b1;
        foreach (g[i]) g[i] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            int exp_idx;
            exp_idx = (c == 0) ? 1 : (c == 1) ? 4 : (c == 2) ? 7 : 1;
            step();
            g = '0; g[exp_idx] = 1'b1;
            chk($sformatf("rr.grant%0d", c), 64'(grant), 64'(g));
            check_model($sformatf("rr%0d", c));
        end
        chk("rr.cnt", 64'(conflict_cnt), 64'd4);

        // Saturation on the 2-bit counter, then clear interactions
        src_out = '0; conflict_clr = 1'b1;
        step();
        conflict_clr = 1'b0;
        src_out[0] = 1'b1; src_out[25] = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("sat.cnt2", 64'(conflict_cnt2), 64'd3);
        chk("sat.cnt",  64'(conflict_cnt),  64'd5);
        conflict_clr = 1'b1;
        step();
        chk("clrconf.cnt2", 64'(conflict_cnt2), 64'd1);
        chk("clrconf.conf", 64'(conflict),      64'd1);
        src_out = '0;
        step();
        conflict_clr = 1'b0;
        chk("clronly.cnt2", 64'(conflict_cnt2), 64'd0);
        chk("clronly.cnt",  64'(conflict_cnt),  64'd0);
        chk("clronly.conf", 64'(conflict),      64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            int nb;
            rand_data();
            req = '0;
            nb = $urandom_range(0, 4);
            if (nb == 4) begin
                req = N'({$urandom, $urandom});
            end else begin
                for (int b = 0; b < nb; b++) req[$urandom_range(0, N - 1)] = 1'b1;
            end
            src_out = req;
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
            conflict_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #2 clr = 1'b1;
                model_reset();
                #1;
                check_model("rnd.rst");
                #1 clr = 1'b0;
            end
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
